// File: rtl/ram_window_streamer.sv
// Image RAM with its own read-address generator, feeding KERNEL
// wavefront-skewed line-buffer rows or a weight stream.
module ram_window_streamer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 11,
  parameter int MAX_WIDTH       = 32,
  parameter int KERNEL          = 5,
  parameter int WAVEFRONT_DELAY = 4,
  parameter int RAM_LATENCY     = 2,
  parameter int DIM_WIDTH       = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         start,
  input  logic                         cfg_weight_mode,
  input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
  input  logic [DIM_WIDTH-1:0]         cfg_width,
  input  logic [DIM_WIDTH-1:0]         cfg_height,
  input  logic                         ram_we,
  input  logic [ADDR_WIDTH-1:0]        ram_waddr,
  input  logic [DATA_WIDTH-1:0]        ram_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic [KERNEL*DATA_WIDTH-1:0] out_data,
  output logic [KERNEL-1:0]            out_valid,
  output logic [DATA_WIDTH-1:0]        weight_out,
  output logic                         weight_valid
);
  localparam int NW  = 2 * DIM_WIDTH;
  localparam int LBW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [7:0] DRAIN_INF =
    8'((KERNEL - 1) * WAVEFRONT_DELAY + RAM_LATENCY + 1);
  localparam logic [7:0] DRAIN_WGT = 8'(RAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [NW-1:0]         cnt_q, cnt_d, n_q, n_d;
  logic [7:0]            dcnt_q, dcnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, raddr_q, raddr_d;
  logic [DIM_WIDTH-1:0]  w_q, w_d;
  logic                  wmode_q, wmode_d, iss_q, iss_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  pclr;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q [RAM_LATENCY];
  logic                  rv_q [RAM_LATENCY];
  logic [DATA_WIDTH-1:0] lb_q [KERNEL-1][MAX_WIDTH];

  logic                  rv;
  logic [DATA_WIDTH-1:0] pix;
  logic [LBW-1:0]        tidx;
  logic [DATA_WIDTH-1:0] tap [KERNEL];
  logic [DATA_WIDTH-1:0] s0d_q [KERNEL], s0d_d [KERNEL];
  logic                  s0v_q [KERNEL], s0v_d [KERNEL];
  logic [NW-1:0]         pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0] wout_q, wout_d;
  logic                  wval_q, wval_d;

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign cfg_err      = err_q;
  assign weight_out   = wout_q;
  assign weight_valid = wval_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    dcnt_d  = dcnt_q;
    base_d  = base_q;
    raddr_d = raddr_q;
    w_d     = w_q;
    wmode_d = wmode_q;
    iss_d   = iss_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pclr    = 1'b0;
    if (en) begin
      iss_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_width == '0 || int'(cfg_width) > MAX_WIDTH ||
                cfg_height == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = READ;
              base_d  = cfg_base_addr;
              w_d     = cfg_width;
              wmode_d = cfg_weight_mode;
              n_d     = NW'(cfg_width) * NW'(cfg_height);
              cnt_d   = '0;
              pclr    = 1'b1;
            end
          end
        end
        READ: begin
          iss_d   = 1'b1;
          raddr_d = base_q + ADDR_WIDTH'(cnt_q);
          if (cnt_q == n_q - NW'(1)) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end
        DRAIN: begin
          if (dcnt_q == (wmode_q ? DRAIN_WGT : DRAIN_INF)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      dcnt_q  <= '0;
      base_q  <= '0;
      raddr_q <= '0;
      w_q     <= '0;
      wmode_q <= 1'b0;
      iss_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      dcnt_q  <= dcnt_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      w_q     <= w_d;
      wmode_q <= wmode_d;
      iss_q   <= iss_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RAM_LATENCY; k++) begin
        rd_q[k] <= '0;
        rv_q[k] <= 1'b0;
      end
    end else if (en) begin
      if (iss_q) rd_q[0] <= mem[raddr_q];
      rv_q[0] <= iss_q;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        rd_q[k] <= rd_q[k-1];
        rv_q[k] <= rv_q[k-1];
      end
    end
  end

  always_comb begin
    rv     = rv_q[RAM_LATENCY-1];
    pix    = wmode_q ? '0 : rd_q[RAM_LATENCY-1];
    tidx   = LBW'(w_q - DIM_WIDTH'(1));
    tap[0] = pix;
    for (int i = 1; i < KERNEL; i++) tap[i] = lb_q[i-1][tidx];
    pcnt_d = pcnt_q;
    s0d_d  = s0d_q;
    s0v_d  = s0v_q;
    wout_d = wout_q;
    wval_d = wval_q;
    if (en) begin
      pcnt_d = pclr ? '0 : pcnt_q + NW'(rv);
      // row i is valid once i full lines have entered the buffer
      for (int i = 0; i < KERNEL; i++) begin
        s0v_d[i] = rv && !wmode_q &&
                   (pcnt_q >= NW'(i) * NW'(w_q));
        s0d_d[i] = s0v_d[i] ? tap[i] : '0;
      end
      wval_d = rv && wmode_q;
      wout_d = wval_d ? rd_q[RAM_LATENCY-1] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      wout_q <= '0;
      wval_q <= 1'b0;
      for (int i = 0; i < KERNEL; i++) begin
        s0d_q[i] <= '0;
        s0v_q[i] <= 1'b0;
      end
    end else begin
      pcnt_q <= pcnt_d;
      wout_q <= wout_d;
      wval_q <= wval_d;
      s0d_q  <= s0d_d;
      s0v_q  <= s0v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en && rv) begin
      for (int k = 0; k < KERNEL - 1; k++) begin
        lb_q[k][0] <= tap[k];
        for (int j = 1; j < MAX_WIDTH; j++) lb_q[k][j] <= lb_q[k][j-1];
      end
    end
  end

  for (genvar i = 0; i < KERNEL; i++) begin : g_row
    if (i == 0) begin : g_direct
      assign out_data[0 +: DATA_WIDTH] = s0d_q[0];
      assign out_valid[0]              = s0v_q[0];
    end else begin : g_skew
      localparam int D = i * WAVEFRONT_DELAY;
      logic [DATA_WIDTH-1:0] sd_q [D];
      logic                  sv_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) begin
            sd_q[k] <= '0;
            sv_q[k] <= 1'b0;
          end
        end else if (en) begin
          sd_q[0] <= s0d_q[i];
          sv_q[0] <= s0v_q[i];
          for (int k = 1; k < D; k++) begin
            sd_q[k] <= sd_q[k-1];
            sv_q[k] <= sv_q[k-1];
          end
        end
      end
      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = sd_q[D-1];
      assign out_valid[i]                         = sv_q[D-1];
    end
  end

endmodule

// File: doc/ram_window_streamer.md
Name: ram_window_streamer

Overview:
- Parametrised successor to the image-RAM/line-buffer feeder.
- Owns its own read-address generator with a start/busy/done handshake, and takes a runtime feature-map size instead of a fixed mode table.
- Provides KERNEL rows, each with a wavefront skew and a per-row valid.
- Routes either to the weight path or the line-buffer path; sits between the host RAM-load interface and the systolic conv array.

Parameters:
DATA_WIDTH, 8, pixel/weight width
ADDR_WIDTH, 11, RAM address width
MAX_WIDTH, 32, max feature-map width; sets line-buffer depth
KERNEL, 5, number of output rows (line-buffer taps)
WAVEFRONT_DELAY, 4, extra cycles of skew per row index
RAM_LATENCY, 2, cycles from address issue to RAM read data
DIM_WIDTH, 6, width of cfg_width/cfg_height

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes the whole read/data pipeline
start  in  1  one-cycle request; sampled only in IDLE
cfg_weight_mode  in  1  1=weight preload, 0=inference (WorI)
cfg_base_addr  in  ADDR_WIDTH  first read address
cfg_width  in  DIM_WIDTH  feature-map width, legal 1..MAX_WIDTH
cfg_height  in  DIM_WIDTH  rows to stream, legal >=1
ram_we  in  1  RAM write enable
ram_waddr  in  ADDR_WIDTH  RAM write address
ram_wdata  in  DATA_WIDTH  RAM write data
busy  out  1  high while not IDLE
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse on rejected start
out_data  out  KERNEL*DATA_WIDTH  row i at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  KERNEL  per-row valid
weight_out  out  DATA_WIDTH  weight stream
weight_valid  out  1  weight_out qualifier

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Reset forces state IDLE, clears all counters and valid/skew pipelines, and drives every output to 0. Reset mid-run aborts the run with no done pulse; RAM contents are not cleared.
- Write port: ram_we/ram_waddr/ram_wdata are always live, independent of state and en. A read and write to the same address in the same cycle returns undefined data; benches must not rely on it.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start with legal cfg: latch all cfg_*, set N = cfg_width*cfg_height, go to READ.
  - start with cfg_width==0, cfg_width>MAX_WIDTH, or cfg_height==0: pulse cfg_err next cycle and stay in IDLE.
  - start outside IDLE is ignored.
- READ: issue addresses for pixels n = 0..N-1, one per enabled cycle. Address = cfg_base_addr + n, wrapping mod 2^ADDR_WIDTH. After issuing n = N-1, go to DRAIN.
- DRAIN: count down the pipeline flush, (KERNEL-1)*WAVEFRONT_DELAY + RAM_LATENCY + 1 enabled cycles in inference mode, RAM_LATENCY + 1 in weight mode. Then pulse done, return to IDLE, and drop busy in the same cycle. A start in the done cycle is accepted.
- en=0: the address counter, RAM read enable, issue-valid pipe, line buffer, skew registers, valids and FSM counters all hold. Outputs hold their values. Timing below counts enabled cycles only.
- Timing, counted from the start-acceptance edge (cycle 0):
  - pixel n address is issued in cycle n+1;
  - row-0 sample for pixel n appears in cycle n+RAM_LATENCY+2;
  - row i sample appears i*WAVEFRONT_DELAY cycles later than row 0.
- Line buffer: row i carries the pixel i*cfg_width positions older than row 0. Depth equals the runtime cfg_width and is never greater than MAX_WIDTH. Line-buffer contents are not cleared at start.
- Valids: out_valid[i] for pixel n is 1 iff inference mode and n >= i*cfg_width. Valids travel through the same skew registers as the data. out_data row i is forced to 0 whenever out_valid[i]=0.
- Weight mode: RAM data goes to weight_out with weight_valid, using row-0 timing. The line buffer is fed 0 and all out_valid bits stay 0. In inference mode weight_out=0 and weight_valid=0.
- done timing: cycle N+RAM_LATENCY+2+(KERNEL-1)*WAVEFRONT_DELAY in inference mode; cycle N+RAM_LATENCY+2 in weight mode.

Test Plan:
- Inference 5x5, defaults, RAM[a]=a[7:0], base 0: out_valid[0] high cycles 4..28 with data 0..24; out_valid[4] first at cycle 40 with data 0 and last at 44 with data 4; done at 45; busy low at 45.
- Weight mode, base 100, width 4, height 1: weight_valid cycles 4..7 with data 100..103; out_valid stays 0; done at 8.
- Same 5x5 run with en=0 for 3 cycles starting at cycle 10: every later event shifts +3, done at 48, and all outputs hold during the stall.
- start with cfg_width=0, then cfg_width=33: cfg_err pulses each time, busy stays 0, no reads issued.
- start pulsed at cycle 10 of a run: ignored, and the run completes unchanged; base 2046, width 4, height 1 reads addresses 2046, 2047, 0, 1.
- rst_n low at cycle 20 of a 5x5 run: all outputs 0 immediately with no done pulse; a fresh start after release reproduces scenario 1 exactly.
